// File: rtl/counter_ud_n.sv
// Synchronous up/down counter with configurable modulus, wrap or saturate at the terminals,
// parallel load and a sticky overflow flag. Its terminal-count outputs allow stages to be chained.
module counter_ud_n #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             npl,
    input  logic [WIDTH-1:0] p,
    input  logic             nce,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             ntcu,
    output logic             ntcd,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bot;

    // Values loaded above MaxVal also count as "at top", so counting up from them wraps.
    assign at_top = (q_q >= MaxVal);
    assign at_bot = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (!npl) begin
            q_d   = p;
            ovf_d = 1'b0;
        end else if (!nce) begin
            if (up) begin
                if (!at_top) begin
                    q_d = q_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    if (!SATURATE) q_d = '0;
                end
            end else begin
                if (!at_bot) begin
                    q_d = q_q - 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    if (!SATURATE) q_d = MaxVal;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // While clr is high q_q is 0 and MaxVal >= 1, so ntcu is 1 and ntcd follows nce/up/npl.
    assign ntcu = !(at_top && up && !nce && npl);
    assign ntcd = !(at_bot && !up && !nce && npl);
    assign q    = q_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_counter_ud_n.sv
// Bench for counter_ud_n: two MAX=9 instances (wrap and saturate) sharing stimulus, plus a
// two-stage 8-bit cascade, all checked every cycle against an arithmetic model.
module tb_counter_ud_n;

    logic       clk = 1'b0;
    logic       clr;
    logic       npl, nce, up;
    logic [3:0] p;
    logic       c_npl, c_nce;

    logic [3:0] dw_q, ds_q, lo_q, hi_q;
    logic       dw_ntcu, dw_ntcd, dw_ovf;
    logic       ds_ntcu, ds_ntcd, ds_ovf;
    logic       lo_ntcu, lo_ntcd, lo_ovf, hi_ntcu, hi_ntcd, hi_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model state.
    int unsigned mw_q = 0, ms_q = 0, m_cnt = 0;
    bit          mw_o = 0, ms_o = 0;

    always #5 clk = ~clk;

    counter_ud_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .clr(clr), .npl(npl), .p(p), .nce(nce), .up(up),
        .q(dw_q), .ntcu(dw_ntcu), .ntcd(dw_ntcd), .ovf(dw_ovf)
    );

    counter_ud_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .clr(clr), .npl(npl), .p(p), .nce(nce), .up(up),
        .q(ds_q), .ntcu(ds_ntcu), .ntcd(ds_ntcd), .ovf(ds_ovf)
    );

    counter_ud_n #(.WIDTH(4)) dut_lo (
        .clk(clk), .clr(clr), .npl(c_npl), .p(4'd0), .nce(c_nce), .up(1'b1),
        .q(lo_q), .ntcu(lo_ntcu), .ntcd(lo_ntcd), .ovf(lo_ovf)
    );

    counter_ud_n #(.WIDTH(4)) dut_hi (
        .clk(clk), .clr(clr), .npl(c_npl), .p(4'd0), .nce(lo_ntcu), .up(1'b1),
        .q(hi_q), .ntcu(hi_ntcu), .ntcd(hi_ntcd), .ovf(hi_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void step(input int unsigned mx, input bit sat,
                                 inout int unsigned mq, inout bit mo);
        if (!npl) begin
            mq = p;
            mo = 1'b0;
        end else if (!nce) begin
            if (up) begin
                if (mq >= mx) begin
                    mo = 1'b1;
                    if (!sat) mq = 0;
                end else begin
                    mq = mq + 1;
                end
            end else begin
                if (mq == 0) begin
                    mo = 1'b1;
                    if (!sat) mq = mx;
                end else begin
                    mq = mq - 1;
                end
            end
        end
    endfunction

    function automatic logic exp_ntcu(input int unsigned mq, input int unsigned mx);
        return !(mq >= mx && up && !nce && npl);
    endfunction

    function automatic logic exp_ntcd(input int unsigned mq);
        return !(mq == 0 && !up && !nce && npl);
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mw_q = 0; mw_o = 0;
            ms_q = 0; ms_o = 0;
            m_cnt = 0;
        end else begin
            step(9, 1'b0, mw_q, mw_o);
            step(9, 1'b1, ms_q, ms_o);
            if (!c_npl) m_cnt = 0;
            else if (!c_nce) m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("w_q", 32'(dw_q), mw_q);
            check("w_ovf", 32'(dw_ovf), 32'(mw_o));
            check("w_ntcu", 32'(dw_ntcu), 32'(exp_ntcu(mw_q, 9)));
            check("w_ntcd", 32'(dw_ntcd), 32'(exp_ntcd(mw_q)));
            check("s_q", 32'(ds_q), ms_q);
            check("s_ovf", 32'(ds_ovf), 32'(ms_o));
            check("s_ntcu", 32'(ds_ntcu), 32'(exp_ntcu(ms_q, 9)));
            check("s_ntcd", 32'(ds_ntcd), 32'(exp_ntcd(ms_q)));
            check("cascade_q", 32'({hi_q, lo_q}), m_cnt);
        end
    end

    // Apply inputs just after a falling edge, then let one rising edge act on them.
    task automatic cyc(input logic n_pl, input logic [3:0] pv, input logic n_ce, input logic u);
        npl = n_pl; p = pv; nce = n_ce; up = u;
        @(negedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        #1;
        check("clr_async_q", 32'(dw_q), 32'd0);
        check("clr_async_ovf", 32'(dw_ovf), 32'd0);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b0; npl = 1'b1; nce = 1'b0; up = 1'b1; p = '0;
        c_npl = 1'b0; c_nce = 1'b1;
        #2 clr = 1'b1;
        #1;
        check("rst_q", 32'(dw_q), 32'd0);
        check("rst_ovf", 32'(dw_ovf), 32'd0);
        check("rst_ntcu", 32'(dw_ntcu), 32'd1);
        check("rst_ntcd_up", 32'(dw_ntcd), 32'd1);
        up = 1'b0;
        #1;
        check("rst_ntcd_down", 32'(dw_ntcd), 32'd0);
        check("rst_ntcu_down", 32'(dw_ntcu), 32'd1);
        up = 1'b1;
        @(negedge clk);
        #1;
        chk_on = 1'b1;
        clr = 1'b0;
        repeat (3) cyc(1, 0, 0, 1);
        check("release_3_edges", 32'(dw_q), 32'd3);

        cyc(0, 8, 1, 1);
        cyc(1, 0, 0, 1);
        check("wrap_up_q9", 32'(dw_q), 32'd9);
        check("wrap_up_ntcu", 32'(dw_ntcu), 32'd0);
        cyc(1, 0, 0, 1);
        check("wrap_up_q0", 32'(dw_q), 32'd0);
        check("wrap_up_ovf", 32'(dw_ovf), 32'd1);
        check("sat_up_q9", 32'(ds_q), 32'd9);

        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check("wrap_down_q", 32'(dw_q), 32'd9);
        check("wrap_down_ovf", 32'(dw_ovf), 32'd1);
        check("sat_down_q", 32'(ds_q), 32'd0);
        check("sat_down_ovf", 32'(ds_ovf), 32'd1);
        check("sat_down_ntcd", 32'(ds_ntcd), 32'd0);

        repeat (5) cyc(0, 4'b1101, 0, 1);
        check("load_prio_q", 32'(dw_q), 32'd13);
        check("load_prio_ovf", 32'(dw_ovf), 32'd0);
        check("load_prio_ntcu", 32'(dw_ntcu), 32'd1);

        cyc(0, 12, 1, 1);
        cyc(1, 0, 0, 1);
        check("oor_up_q", 32'(dw_q), 32'd0);
        check("oor_up_ovf", 32'(dw_ovf), 32'd1);
        cyc(0, 12, 1, 1);
        cyc(1, 0, 0, 0);
        check("oor_down_11", 32'(dw_q), 32'd11);
        cyc(1, 0, 0, 0);
        check("oor_down_10", 32'(dw_q), 32'd10);
        cyc(1, 0, 0, 0);
        check("oor_down_9", 32'(dw_q), 32'd9);

        cyc(1, 0, 0, 1);
        clr_pulse();
        cyc(1, 0, 0, 1);
        check("after_clr_counts", 32'(dw_q), 32'd1);

        // Cascade: release its load and count 300 edges.
        c_npl = 1'b1; c_nce = 1'b0;
        repeat (300) cyc(1, 0, 1, 1);
        check("cascade_300", 32'({hi_q, lo_q}), 32'd44);

        for (int i = 0; i < 2000; i++) begin
            c_npl = ($urandom_range(31) == 0);
            c_npl = !c_npl;
            c_nce = ($urandom_range(3) == 0);
            cyc(($urandom_range(7) != 0), 4'($urandom_range(15)),
                ($urandom_range(4) == 0), 1'($urandom_range(1)));
            if ($urandom_range(63) == 0) clr_pulse();
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
